// File: rtl/genpad_port_emulator.sv
// Emulated Mega Drive controller port: answers the core's TH select with the
// six active-low port lines for SMS, 3-button and 6-button pads.
module genpad_port_emulator #(
  parameter int unsigned TIMEOUT_CYCLES = 75000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [1:0]  iPAD_TYPE,
  input  logic [11:0] iBUTTONS,
  input  logic        iTH,
  output logic [5:0]  oPORT,
  output logic [2:0]  oPHASE
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] PAD_SMS  = 2'b00;
  localparam logic [1:0] PAD_3BTN = 2'b01;
  localparam logic [1:0] PAD_6BTN = 2'b10;
  localparam logic [1:0] PAD_NONE = 2'b11;

  localparam int unsigned BTN_R = 0;
  localparam int unsigned BTN_L = 1;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_U = 3;
  localparam int unsigned BTN_A = 4;
  localparam int unsigned BTN_B = 5;
  localparam int unsigned BTN_C = 6;
  localparam int unsigned BTN_S = 7;
  localparam int unsigned BTN_M = 8;
  localparam int unsigned BTN_X = 9;
  localparam int unsigned BTN_Y = 10;
  localparam int unsigned BTN_Z = 11;

  logic               th_q,    th_d;
  logic [1:0]         type_q,  type_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         phase_q, phase_d;
  logic [5:0]         port_q,  port_d;

  logic       th_edge;
  logic       type_chg;
  logic       timeout;
  logic [2:0] phase_base;
  logic [5:0] hi_grp;
  logic [5:0] lo_grp;
  logic [5:0] six_grp;

  // TH edge detect, inactivity timer and 6-button phase counter
  always_comb begin
    th_edge    = iTH ^ th_q;
    type_chg   = (iPAD_TYPE != type_q);
    timeout    = (timer_q == TIMER_MAX);
    th_d       = iTH;
    type_d     = iPAD_TYPE;
    timer_d    = timer_q;
    phase_d    = phase_q;
    phase_base = timeout ? 3'd0 : phase_q;

    if (type_chg || th_edge) begin
      timer_d = '0;
    end else if (!timeout) begin
      timer_d = timer_q + TIMER_W'(1);
    end

    // timeout clears the phase first, so a coincident edge lands on phase 1
    if ((iPAD_TYPE != PAD_6BTN) || type_chg) begin
      phase_d = 3'd0;
    end else if (th_edge) begin
      phase_d = phase_base + 3'd1;
    end else begin
      phase_d = phase_base;
    end
  end

  // Port line groups; a 0 on a line means pressed / pulled low
  always_comb begin
    hi_grp  = ~{iBUTTONS[BTN_C], iBUTTONS[BTN_B], iBUTTONS[BTN_U],
                iBUTTONS[BTN_D], iBUTTONS[BTN_L], iBUTTONS[BTN_R]};
    lo_grp  = {~iBUTTONS[BTN_S], ~iBUTTONS[BTN_A], ~iBUTTONS[BTN_U],
               ~iBUTTONS[BTN_D], 2'b00};
    six_grp = {2'b11, ~iBUTTONS[BTN_Z], ~iBUTTONS[BTN_Y],
               ~iBUTTONS[BTN_X], ~iBUTTONS[BTN_M]};
  end

  // Output mux, driven by the next phase so the answer tracks TH with one clock latency
  always_comb begin
    port_d = 6'b111111;
    case (iPAD_TYPE)
      PAD_SMS: begin
        port_d = hi_grp;
      end
      PAD_3BTN: begin
        port_d = iTH ? hi_grp : lo_grp;
      end
      PAD_6BTN: begin
        if (iTH) begin
          port_d = (phase_d == 3'd6) ? six_grp : hi_grp;
        end else begin
          case (phase_d)
            3'd5:    port_d = {lo_grp[5:4], 4'b0000};
            3'd7:    port_d = {lo_grp[5:4], 4'b1111};
            default: port_d = lo_grp;
          endcase
        end
      end
      PAD_NONE: begin
        port_d = 6'b111111;
      end
      default: begin
        port_d = 6'b111111;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      th_q    <= 1'b1;
      type_q  <= PAD_NONE;
      timer_q <= '0;
      phase_q <= 3'd0;
      port_q  <= 6'b111111;
    end else begin
      th_q    <= th_d;
      type_q  <= type_d;
      timer_q <= timer_d;
      phase_q <= phase_d;
      port_q  <= port_d;
    end
  end

  assign oPORT  = port_q;
  assign oPHASE = phase_q;

endmodule

// File: tb/tb_genpad_port_emulator.sv
// Directed bench for genpad_port_emulator: each step drives inputs, queues the
// expected port/phase and compares them one clock later.
module tb_genpad_port_emulator;

  localparam int unsigned TO = 100;

  logic        iCLK;
  logic        iRST_N;
  logic [1:0]  iPAD_TYPE;
  logic [11:0] iBUTTONS;
  logic        iTH;
  logic [5:0]  oPORT;
  logic [2:0]  oPHASE;

  int errors;
  int checks;

  string      tag_q[$];
  logic [5:0] port_q[$];
  logic [2:0] phase_q[$];

  genpad_port_emulator #(.TIMEOUT_CYCLES(TO)) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iPAD_TYPE (iPAD_TYPE),
    .iBUTTONS  (iBUTTONS),
    .iTH       (iTH),
    .oPORT     (oPORT),
    .oPHASE    (oPHASE)
  );

  initial begin
    iCLK = 1'b0;
    forever #10 iCLK = ~iCLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_out();
    string      t;
    logic [5:0] ep;
    logic [2:0] eh;
    checks++;
    assert (tag_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty got=0 exp=1");
    end
    if (tag_q.size() != 0) begin
      t  = tag_q.pop_front();
      ep = port_q.pop_front();
      eh = phase_q.pop_front();
      checks++;
      assert (oPORT === ep) else begin
        errors++;
        $error("FAIL %s oPORT got=%b exp=%b", t, oPORT, ep);
      end
      checks++;
      assert (oPHASE === eh) else begin
        errors++;
        $error("FAIL %s oPHASE got=%0d exp=%0d", t, oPHASE, eh);
      end
    end
  endtask

  task automatic step(input string tag, input logic rst_n, input logic [1:0] ptype,
                      input logic [11:0] btn, input logic th,
                      input logic [5:0] e_port, input logic [2:0] e_phase);
    iRST_N    = rst_n;
    iPAD_TYPE = ptype;
    iBUTTONS  = btn;
    iTH       = th;
    tag_q.push_back(tag);
    port_q.push_back(e_port);
    phase_q.push_back(e_phase);
    @(negedge iCLK);
    check_out();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // reset
    step("rst",      1'b0, 2'b10, 12'h000, 1'b1, 6'b111111, 3'd0);
    step("rst_hold", 1'b0, 2'b10, 12'h000, 1'b1, 6'b111111, 3'd0);
    step("rst_rel",  1'b1, 2'b10, 12'h000, 1'b1, 6'b111111, 3'd0);

    // SMS: TH ignored
    step("sms_th1",  1'b1, 2'b00, 12'h021, 1'b1, 6'b101110, 3'd0);
    step("sms_th0",  1'b1, 2'b00, 12'h021, 1'b0, 6'b101110, 3'd0);
    step("sms_th1b", 1'b1, 2'b00, 12'h021, 1'b1, 6'b101110, 3'd0);
    step("sms_btn0", 1'b1, 2'b00, 12'h000, 1'b1, 6'b111111, 3'd0);

    // 3-button
    step("3b_th1",    1'b1, 2'b01, 12'h090, 1'b1, 6'b111111, 3'd0);
    step("3b_th0",    1'b1, 2'b01, 12'h090, 1'b0, 6'b001100, 3'd0);
    step("3b_ul_th0", 1'b1, 2'b01, 12'h00A, 1'b0, 6'b110100, 3'd0);
    step("3b_ul_th1", 1'b1, 2'b01, 12'h00A, 1'b1, 6'b110101, 3'd0);

    // 6-button full cycle with Z and M held
    step("6b_p0", 1'b1, 2'b10, 12'h900, 1'b1, 6'b111111, 3'd0);
    idle(10);
    step("6b_p1", 1'b1, 2'b10, 12'h900, 1'b0, 6'b111100, 3'd1);
    idle(10);
    step("6b_p2", 1'b1, 2'b10, 12'h900, 1'b1, 6'b111111, 3'd2);
    idle(10);
    step("6b_p3", 1'b1, 2'b10, 12'h900, 1'b0, 6'b111100, 3'd3);
    idle(10);
    step("6b_p4", 1'b1, 2'b10, 12'h900, 1'b1, 6'b111111, 3'd4);
    idle(10);
    step("6b_p5", 1'b1, 2'b10, 12'h900, 1'b0, 6'b110000, 3'd5);
    idle(10);
    step("6b_p6", 1'b1, 2'b10, 12'h900, 1'b1, 6'b110110, 3'd6);
    idle(10);
    step("6b_p7", 1'b1, 2'b10, 12'h900, 1'b0, 6'b111111, 3'd7);
    idle(10);
    step("6b_wrap", 1'b1, 2'b10, 12'h900, 1'b1, 6'b111111, 3'd0);
    step("6b_btn_mid", 1'b1, 2'b10, 12'h940, 1'b1, 6'b011111, 3'd0);

    // timeout boundaries
    step("to_p1", 1'b1, 2'b10, 12'h900, 1'b0, 6'b111100, 3'd1);
    idle(10);
    step("to_p2", 1'b1, 2'b10, 12'h900, 1'b1, 6'b111111, 3'd2);
    idle(10);
    step("to_p3", 1'b1, 2'b10, 12'h900, 1'b0, 6'b111100, 3'd3);
    idle(TO - 1);
    step("to_edge_before", 1'b1, 2'b10, 12'h900, 1'b1, 6'b111111, 3'd4);
    idle(TO - 1);
    step("to_hold",        1'b1, 2'b10, 12'h900, 1'b1, 6'b111111, 3'd4);
    step("to_edge_at",     1'b1, 2'b10, 12'h900, 1'b0, 6'b111100, 3'd1);
    idle(TO - 1);
    step("to_pre",         1'b1, 2'b10, 12'h900, 1'b0, 6'b111100, 3'd1);
    step("to_expire",      1'b1, 2'b10, 12'h900, 1'b0, 6'b111100, 3'd0);
    idle(20);
    step("to_sat_edge",    1'b1, 2'b10, 12'h900, 1'b1, 6'b111111, 3'd1);

    // type change 6-btn -> 3-btn at phase 4
    idle(10);
    step("tc_p2", 1'b1, 2'b10, 12'h900, 1'b0, 6'b111100, 3'd2);
    idle(10);
    step("tc_p3", 1'b1, 2'b10, 12'h900, 1'b1, 6'b111111, 3'd3);
    idle(10);
    step("tc_p4", 1'b1, 2'b10, 12'h900, 1'b0, 6'b111100, 3'd4);
    step("tc_to3b",    1'b1, 2'b01, 12'h090, 1'b0, 6'b001100, 3'd0);
    step("tc_3b_th1",  1'b1, 2'b01, 12'h090, 1'b1, 6'b111111, 3'd0);

    // no pad, and SMS with everything pressed
    step("none",     1'b1, 2'b11, 12'hFFF, 1'b1, 6'b111111, 3'd0);
    step("none_th0", 1'b1, 2'b11, 12'hFFF, 1'b0, 6'b111111, 3'd0);
    step("sms_all",  1'b1, 2'b00, 12'hFFF, 1'b0, 6'b000000, 3'd0);

    // TH/phase parity mismatch: TH level picks the group
    step("par_p0", 1'b1, 2'b10, 12'h900, 1'b0, 6'b111100, 3'd0);
    step("par_p1", 1'b1, 2'b10, 12'h900, 1'b1, 6'b111111, 3'd1);

    // reset mid-sequence
    step("rst_mid",     1'b0, 2'b10, 12'h900, 1'b1, 6'b111111, 3'd0);
    step("rst_mid_rel", 1'b1, 2'b10, 12'h900, 1'b1, 6'b111111, 3'd0);
    step("post_rst_p1", 1'b1, 2'b10, 12'h900, 1'b0, 6'b111100, 3'd1);

    checks++;
    assert (tag_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover got=%0d exp=0", tag_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
